// File: rtl/sram_burst_ctrl_pkg.sv
// Shared types and constants for the SRAM burst request front end.
// Imported by the interface, the response FIFO and the controller top.
package sram_ctrl_pkg;

    localparam int unsigned WORD_BYTES = 16;
    localparam int unsigned DATA_W     = 128;
    localparam int unsigned STRB_W     = 16;
    localparam int unsigned MAX_BURST  = 16;
    localparam int unsigned RSP_DEPTH  = 2;
    localparam int unsigned OFF_W      = $clog2(WORD_BYTES);

    localparam logic [STRB_W-1:0] WEN_NONE = '1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RDRAIN
    } state_e;

    // One buffered read beat: data plus the burst-final tag.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } rsp_t;

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Command, write-data, completion, read-data and SRAM pin bundle of the
// burst controller; slave is the controller view, master the client/macro view.
interface sram_burst_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 21,
    parameter int unsigned MAX_LEN_W  = 4
);
    import sram_ctrl_pkg::*;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDR_WIDTH+3:0]   cmd_addr;
    logic [MAX_LEN_W-1:0]    cmd_len;

    logic                    wd_valid;
    logic                    wd_ready;
    logic [DATA_W-1:0]       wd_data;
    logic [STRB_W-1:0]       wd_strb;
    logic                    wd_last;

    logic                    wr_done_valid;
    logic                    wr_done_ready;
    logic                    wr_done_err;

    logic                    rd_valid;
    logic                    rd_ready;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_last;

    logic [ADDR_WIDTH-1:0]   sram_a;
    logic                    sram_cen;
    logic [STRB_W-1:0]       sram_wen;
    logic [DATA_W-1:0]       sram_d;
    logic [DATA_W-1:0]       sram_q;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        input  wd_valid, wd_data, wd_strb, wd_last,
        output wd_ready,
        output wr_done_valid, wr_done_err,
        input  wr_done_ready,
        output rd_valid, rd_data, rd_last,
        input  rd_ready,
        output sram_a, sram_cen, sram_wen, sram_d,
        input  sram_q
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        output wd_valid, wd_data, wd_strb, wd_last,
        input  wd_ready,
        input  wr_done_valid, wr_done_err,
        output wr_done_ready,
        input  rd_valid, rd_data, rd_last,
        output rd_ready,
        input  sram_a, sram_cen, sram_wen, sram_d,
        output sram_q
    );

endinterface

// File: rtl/sram_burst_ctrl_rsp_fifo.sv
// Two-entry synchronous FIFO that absorbs the SRAM read latency so read
// beats survive back-pressure; emptied by the synchronous reset.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       push_i,
    input  rsp_t       push_data_i,
    input  logic       pop_i,
    output rsp_t       head_o,
    output logic [1:0] count_o,
    output logic       empty_o,
    output logic       full_o
);

    rsp_t       mem_q [RSP_DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push_ok;
    logic       pop_ok;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted in.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(push_i && full_o && !pop_i));

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst command front end for the 128-bit single-port SRAM: drives the macro
// pins for write/read bursts, buffers read data and returns write completions.
module sram_burst_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 21,
    parameter int unsigned MAX_LEN_W  = 4
) (
    input  logic CLK,
    input  logic RST,
    sram_burst_ctrl_if.slave bus
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MAX_LEN_W-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  inflight_q;
    logic                  inflight_last_q, inflight_last_d;

    logic                  last_beat;
    logic                  rd_valid_w;
    logic                  rd_pop;
    logic                  rd_issue;
    logic [2:0]            rd_occ;
    logic                  rd_room;

    rsp_t                  fifo_head;
    rsp_t                  fifo_push_data;
    logic [1:0]            fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  unused_byte_offset;

    assign unused_byte_offset = ^{bus.cmd_addr[OFF_W-1:0], fifo_full};

    assign last_beat = (cnt_q == '0);

    assign rd_valid_w = !fifo_empty && !RST;
    assign rd_pop     = rd_valid_w && bus.rd_ready;

    // Room is judged after this cycle's pop, so a draining FIFO keeps 1 beat/cycle.
    assign rd_occ  = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign rd_room = (rd_occ < (3'd2 + {2'b00, rd_pop}));

    assign fifo_push_data = '{last: inflight_last_q, data: bus.sram_q};

    sram_rsp_fifo u_rsp_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .push_i      (inflight_q),
        .push_data_i (fifo_push_data),
        .pop_i       (rd_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign bus.rd_valid = rd_valid_w;
    assign bus.rd_data  = fifo_head.data;
    assign bus.rd_last  = fifo_head.last;

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        cnt_d             = cnt_q;
        err_d             = err_q;
        inflight_last_d   = inflight_last_q;
        rd_issue          = 1'b0;

        bus.cmd_ready     = 1'b0;
        bus.wd_ready      = 1'b0;
        bus.wr_done_valid = 1'b0;
        bus.wr_done_err   = 1'b0;
        bus.sram_cen      = 1'b1;
        bus.sram_wen      = WEN_NONE;
        bus.sram_a        = RST ? '0 : addr_q;
        bus.sram_d        = '0;

        if (!RST) begin
            unique case (state_q)
                IDLE: begin
                    bus.cmd_ready = 1'b1;
                    if (bus.cmd_valid) begin
                        addr_d  = bus.cmd_addr[ADDR_WIDTH+OFF_W-1:OFF_W];
                        cnt_d   = bus.cmd_len;
                        err_d   = 1'b0;
                        state_d = bus.cmd_write ? WRITE : READ;
                    end
                end

                WRITE: begin
                    bus.wd_ready = 1'b1;
                    if (bus.wd_valid) begin
                        bus.sram_cen = 1'b0;
                        bus.sram_wen = ~bus.wd_strb;
                        bus.sram_d   = bus.wd_data;
                        err_d        = err_q | (bus.wd_last != last_beat);
                        addr_d       = addr_q + 1'b1;
                        cnt_d        = cnt_q - 1'b1;
                        if (last_beat) begin
                            state_d = WRESP;
                        end
                    end
                end

                WRESP: begin
                    bus.wr_done_valid = 1'b1;
                    bus.wr_done_err   = err_q;
                    if (bus.wr_done_ready) begin
                        state_d = IDLE;
                    end
                end

                READ: begin
                    if (rd_room) begin
                        rd_issue        = 1'b1;
                        bus.sram_cen    = 1'b0;
                        inflight_last_d = last_beat;
                        addr_d          = addr_q + 1'b1;
                        cnt_d           = cnt_q - 1'b1;
                        if (last_beat) begin
                            state_d = RDRAIN;
                        end
                    end
                end

                RDRAIN: begin
                    if (!inflight_q && (fifo_count == {1'b0, rd_pop})) begin
                        state_d = IDLE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            cnt_q           <= '0;
            err_q           <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            cnt_q           <= cnt_d;
            err_q           <= err_d;
            inflight_q      <= rd_issue;
            inflight_last_q <= inflight_last_d;
        end
    end

endmodule

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
- Request front end that sits directly upstream of the 128-bit single-port SRAM macro in the smart_run memory subsystem.
- Accepts burst commands (up to 16 beats) on valid/ready channels and drives the SRAM A/CEN/WEN/D pins.
- Absorbs the SRAM's one-cycle read latency in a 2-entry response buffer, so read data can be back-pressured without losing beats.
- Issues a single completion token per write burst.

Parameters:
- ADDR_WIDTH, 21: SRAM word-address width. Byte address width is ADDR_WIDTH+4.
- MAX_LEN_W, 4: burst-length field width; bursts are 1..2^MAX_LEN_W beats.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH+4  byte start address; bits [3:0] ignored.
- cmd_len  in  MAX_LEN_W  beats minus 1.
- wd_valid / wd_ready  in / out  1  write-data handshake.
- wd_data  in  128  write beat.
- wd_strb  in  16  byte enables, active high.
- wd_last  in  1  producer's final-beat marker; checked, not used for termination.
- wr_done_valid / wr_done_ready  out / in  1  write-completion handshake.
- wr_done_err  out  1  last-marker mismatch seen in the completed burst.
- rd_valid / rd_ready  out / in  1  read-data handshake.
- rd_data  out  128  read beat.
- rd_last  out  1  final beat of the read burst.
- sram_a  out  ADDR_WIDTH  SRAM word address.
- sram_cen  out  1  SRAM chip enable, active low.
- sram_wen  out  16  per-byte write enable, active low.
- sram_d  out  128  SRAM write data.
- sram_q  in  128  SRAM read data, valid one cycle after the read access.

Behaviour:
- States: IDLE, WRITE, WRESP, READ, RDRAIN.
  - Registers: word address addr_q, beat counter cnt_q, err_q, inflight_q (1 bit), 2-entry FIFO holding {data, last}.
- Reset (RST high at an edge): state=IDLE, cnt_q=0, addr_q=0, err_q=0, inflight_q=0, FIFO emptied.
  - While RST is high, outputs are forced to: cmd_ready=0, wd_ready=0, wr_done_valid=0, rd_valid=0, sram_cen=1, sram_wen=16'hFFFF, sram_a=0, sram_d=0.
  - Reset mid-burst abandons the burst. No further SRAM access occurs and the partial write is not undone.
- IDLE:
  - cmd_ready=1.
  - On accept: addr_q = cmd_addr[ADDR_WIDTH+3:4], cnt_q = cmd_len, err_q = 0.
  - Next state is WRITE or READ.
  - No SRAM access in IDLE: cen=1, wen all ones.
- WRITE:
  - wd_ready=1.
  - Each accepted beat drives the SRAM combinationally in the same cycle: sram_cen=0, sram_a=addr_q, sram_d=wd_data, sram_wen=~wd_strb. The macro writes at the closing edge.
  - A beat with strb=0 still asserts cen with wen all ones, i.e. a harmless read.
  - Per beat: err_q |= (wd_last != (cnt_q==0)). addr_q increments by 1 modulo 2^ADDR_WIDTH (wraps 0x1FFFFF -> 0). cnt_q decrements.
  - The beat accepted with cnt_q==0 moves the block to WRESP.
  - No accepted beat: cen=1.
- WRESP:
  - wr_done_valid=1, wr_done_err=err_q.
  - On wr_done_ready -> IDLE.
  - Next cmd_ready is one cycle later (no same-cycle bypass).
- READ:
  - Issue condition: (fifo_count + inflight_q - pop) < 2, where pop = rd_valid & rd_ready.
  - On issue: sram_cen=0, wen all ones, sram_a=addr_q. inflight_q is set with its last-tag = (cnt_q==0). addr_q wraps as for writes. cnt_q decrements.
  - The issue with cnt_q==0 moves the block to RDRAIN.
- Read data capture:
  - Whenever inflight_q=1, sram_q is pushed into the FIFO at the closing edge of that cycle and inflight_q clears (unless re-set by a new issue).
  - Back-to-back issues sustain 1 beat/cycle while rd_ready=1.
- rd_valid = FIFO non-empty; rd_data / rd_last come from the FIFO head.
  - Latency: issue in cycle N -> rd_valid earliest in cycle N+2.
  - Simultaneous push and pop on a full FIFO cannot occur, by the issue rule.
- RDRAIN: no issues; -> IDLE when FIFO empty and inflight_q=0 (checked after the cycle's pop).
- Between accesses sram_a holds addr_q. The SRAM keeps Q stable across idle cycles by its own address hold.

Decomposition:
- Shared package sram_ctrl_pkg:
  - state enum {IDLE, WRITE, WRESP, READ, RDRAIN}
  - WORD_BYTES=16, DATA_W=128, STRB_W=16
  - MAX_BURST=16
- One sub-module: sram_rsp_fifo, a 2-entry, 129-bit synchronous FIFO with push/pop/count, reset to empty on RST.

Test Plan:
- Write cmd addr=0x100, len=3, beats 0xA0..0xA3 with full strb and wd_last only on the 4th beat. Required: sram_a = 0x10,0x11,0x12,0x13 on consecutive cycles; wr_done_err=0. Then a read of the same range returns 0xA0..0xA3 with rd_last on the 4th beat.
- Read len=15 with rd_ready constantly 1. Required: 16 consecutive sram_cen=0 cycles, rd_valid continuous from issue+2, no bubbles.
- Read len=7 with rd_ready toggling 1,0,0,1. Required: at most 2 beats buffered, no beat lost or duplicated, data order preserved, sram_cen deasserted while stalled.
- Write at byte addr 0x1FFFFF0 (top word), len=1. Required: sram_a=0x1FFFFF then 0x000000. A partial strb 16'h000F gives sram_wen=16'hFFF0.
- Write len=2 with wd_last asserted on beat 2 (early). Required: 3 beats still written, wr_done_err=1. wr_done_ready held low 5 cycles -> wr_done_valid held, cmd_ready=0.
- RST asserted mid read burst (beat 3 of 8). Required: next cycle sram_cen=1, rd_valid=0, state IDLE, cmd_ready=1 after RST deasserts.
